operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/rf_pkg.sv | 6 +
 rtl/reg_scoreboard.sv | 35 +++
 rtl/operand_fetch.sv | 89 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file sizing defaults and the hard-wired zero register address.
package rf_pkg;
  localparam int ADDRSIZE_DEF = 5;
  localparam int WORDSIZE_DEF = 32;
  localparam int REG0 = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write bits, their population count and a sticky stray-writeback flag.
module reg_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_i,
  input  logic [ADDRSIZE-1:0]    set_rd_i,
  input  logic                   wb_valid_i,
  input  logic [ADDRSIZE-1:0]    wb_rd_i,
  output logic [2**ADDRSIZE-1:0] busy_o,
  output logic [ADDRSIZE:0]      busy_cnt_o,
  output logic                   wb_err_o
);
  localparam int N = 2**ADDRSIZE;
  logic [N-1:0] busy_q, busy_d, set_m, clr_m;
  logic [ADDRSIZE:0] cnt_q;
  logic wb_err_q;
  // set is applied after clear so an issue and a writeback to one register leave it busy
  always_comb begin
    set_m = set_i ? N'(1) << set_rd_i : '0;
    clr_m = (wb_valid_i && busy_q[wb_rd_i]) ? N'(1) << wb_rd_i : '0;
    busy_d = ((busy_q & ~clr_m) | set_m) & ~N'(1);
  end
  always_ff @(posedge clk) begin
    busy_q   <= rst ? '0 : busy_d;
    cnt_q    <= rst ? '0 : (ADDRSIZE+1)'($countones(busy_d));
    wb_err_q <= rst ? 1'b0 : wb_err_q | (wb_valid_i && !busy_q[wb_rd_i]);
  end
  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;
  assign wb_err_o   = wb_err_q;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: scoreboarded operand read stage with a one-entry output register.
// Define FORWARD_EN to bypass a same-cycle writeback into a waiting source operand.
module operand_fetch
  import rf_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int WORDSIZE = WORDSIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDRSIZE-1:0] in_rs1,
  input  logic [ADDRSIZE-1:0] in_rs2,
  input  logic [ADDRSIZE-1:0] in_rd,
  input  logic                in_wen,
  output logic [ADDRSIZE-1:0] rs1,
  output logic [ADDRSIZE-1:0] rs2,
  input  logic [WORDSIZE-1:0] rs1data,
  input  logic [WORDSIZE-1:0] rs2data,
  input  logic                wb_valid,
  input  logic [ADDRSIZE-1:0] wb_rd,
  input  logic [WORDSIZE-1:0] wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_op1,
  output logic [WORDSIZE-1:0] out_op2,
  output logic [ADDRSIZE-1:0] out_rd,
  output logic                out_wen,
  output logic [ADDRSIZE:0]   busy_cnt,
  output logic                wb_err
);
  localparam logic [ADDRSIZE-1:0] R0 = ADDRSIZE'(REG0);
  logic [2**ADDRSIZE-1:0] busy;
  logic fwd1, fwd2, hazard, accept;
  logic valid_q, wen_q;
  logic [WORDSIZE-1:0] op1_q, op2_q, op1_d, op2_d;
  logic [ADDRSIZE-1:0] rd_q;
  assign rs1 = in_rs1;
  assign rs2 = in_rs2;
`ifdef FORWARD_EN
  assign fwd1 = wb_valid && busy[in_rs1] && wb_rd == in_rs1;
  assign fwd2 = wb_valid && busy[in_rs2] && wb_rd == in_rs2;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  // busy[0] is held low, so address 0 never contributes a hazard
  assign hazard = (busy[in_rs1] && !fwd1) || (busy[in_rs2] && !fwd2) || (in_wen && busy[in_rd]);
  assign in_ready = !hazard && (!valid_q || out_ready);
  assign accept = in_valid && in_ready;
  always_comb begin
    op1_d = in_rs1 == R0 ? '0 : fwd1 ? wb_data : rs1data;
    op2_d = in_rs2 == R0 ? '0 : fwd2 ? wb_data : rs2data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= in_rd;
      wen_q   <= in_wen;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end
  reg_scoreboard #(.ADDRSIZE(ADDRSIZE)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_i     (accept && in_wen && in_rd != R0),
    .set_rd_i  (in_rd),
    .wb_valid_i(wb_valid),
    .wb_rd_i   (wb_rd),
    .busy_o    (busy),
    .busy_cnt_o(busy_cnt),
    .wb_err_o  (wb_err)
  );
  assign out_valid = valid_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_rd    = rd_q;
  assign out_wen   = wen_q;
endmodule
